mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_DM_STREAK, default 4, max consecutive DM grants while IF waits.
REQ-002 Parameter: ACK_TIMEOUT, default 255, cycles in BUSY without mem_ack before error.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_req / if_flush  input  1/1  fetch request (level) / cancel outstanding fetch.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_rdata / if_valid / if_err  output  32/1/1  fetch data, 1-cycle completion pulse, error with valid.
REQ-008 dm_req / dm_we  input  1/1  data request (level) / write when 1.
REQ-009 dm_addr / dm_wdata / dm_be  input  32/32/4  data address, write data, byte enables.
REQ-010 dm_rdata / dm_valid / dm_err  output  32/1/1  load data, completion pulse, error with valid.
REQ-011 mem_req / mem_we / mem_addr / mem_wdata / mem_be  output  1/1/32/32/4  registered single memory port.
REQ-012 mem_rdata / mem_ack  input  32/1  memory read data, completion strobe (variable latency, >=1 cycle).
REQ-013 if_stall / dm_stall  output  1/1  combinational: req high and corresponding valid low.

Function
REQ-014 FSM states SHALL be IDLE, BUSY_IF, BUSY_DM, RESP.
REQ-015 IDLE: dm_req -> BUSY_DM, else if_req and not if_flush -> BUSY_IF, else stay; dm_req outranks if_req unless streak count = MAX_DM_STREAK and if_req high, then IF wins.
REQ-016 Grant at cycle N: mem_req, mem_addr, mem_we, mem_wdata, mem_be registered, valid from N+1; mem_we=0, mem_be=4'hF for IF grants.
REQ-017 BUSY_*: mem_* held constant until mem_ack sampled high at cycle M; mem_req low from M+1.
REQ-018 On ack at M: mem_rdata captured; FSM -> RESP; served requester's valid high exactly in M+1; rdata stable in M+1.
REQ-019 RESP: no grant decision; -> IDLE next cycle; requester must drop or replace req in the cycle after valid.
REQ-020 Writes: dm_valid pulses, dm_rdata = 0.
REQ-021 Streak counter: +1 on DM grant while if_req high, cleared on IF grant or when if_req low at a DM grant; saturates at MAX_DM_STREAK.
REQ-022 if_flush in IDLE blocks IF grant that cycle; in BUSY_IF sets discard flag; in RESP (IF) suppresses if_valid.
REQ-023 Discard flag: memory transaction completes normally, if_valid/if_err not asserted, flag cleared in RESP.
REQ-024 if_flush has no effect on DM transactions.
REQ-025 Timeout counter cleared on grant, +1 per BUSY cycle; at ACK_TIMEOUT: mem_req dropped, -> RESP, valid plus *_err pulse, rdata = 0.
REQ-026 mem_ack in IDLE or RESP SHALL be ignored.
REQ-027 mem_ack on the same cycle as timeout expiry: ack wins, no error.
REQ-028 Simultaneous if_req and dm_req with streak below limit: DM served first, IF granted in the IDLE after RESP.

Reset
REQ-029 rst_n low: immediately state IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_valid, dm_valid, if_err, dm_err, if_rdata, dm_rdata = 0; counters and discard flag = 0.
REQ-030 Reset mid-transaction abandons it; no valid issued after release; first grant is possible in the first clock after release.

Structure
REQ-031 State enum mem_arb_state_t and default MAX_DM_STREAK/ACK_TIMEOUT constants SHALL live in shared package rv32i, beside INST_WIDTH.
REQ-032 Timeout counter SHALL be sub-module arb_timeout_counter (clear, enable, expired); rest flat.

Verification
REQ-033 IF read, ack 3 cycles after mem_req: if_req@0, addr 0x100 -> mem_req 1..3, if_valid@4 with rdata 0xDEADBEEF, mem_req again no earlier than 6.
REQ-034 if_req and dm_req together, DM load 0x2000 -> DM served first, IF granted in the IDLE after dm_valid.
REQ-035 dm_req continuous, if_req high -> after 4 DM grants IF granted; streak reset.
REQ-036 if_flush during BUSY_IF -> memory ack consumed, no if_valid, next IF grant unaffected.
REQ-037 No mem_ack for 255 BUSY cycles on DM store -> mem_req drops, dm_valid+dm_err one cycle, dm_rdata 0.
REQ-038 rst_n low during BUSY_DM -> mem_req 0 same cycle (async); no dm_valid after release.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared core package: common widths, arbiter state encoding and default
// arbiter limits used by the memory-port arbiter and its helpers.
package rv32i;

  localparam int INST_WIDTH = 32;
  localparam int XLEN       = 32;

  // Default arbiter limits
  localparam int DEF_MAX_DM_STREAK = 4;
  localparam int DEF_ACK_TIMEOUT   = 255;

  // All byte lanes enabled (instruction fetches are always full words)
  localparam logic [3:0] BE_WORD = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } mem_arb_state_t;

  // Bits needed to hold values 0..max_val (never less than one bit)
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Busy-cycle counter for the memory-port arbiter. Cleared on every grant,
// counts each busy cycle, and flags expiry during the LIMIT-th busy cycle.
module arb_timeout_counter
  import rv32i::*;
#(
  parameter int LIMIT = DEF_ACK_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_reg;

  // Count busy cycles since the last grant; hold at the last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // count_reg holds the number of busy cycles already completed, so the
  // LIMIT-th busy cycle is the one where it equals LIMIT-1
  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one registered
// memory port. Data wins by default; a streak counter guarantees fetch
// progress, a discard flag absorbs flushed fetches, and a timeout turns a
// missing acknowledge into an error completion.
module mem_port_arbiter
  import rv32i::*;
#(
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK,
  parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction fetch side
  input  logic                  if_req,
  input  logic                  if_flush,
  input  logic [XLEN-1:0]       if_addr,
  output logic [INST_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  output logic                  if_err,
  // data side
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [XLEN-1:0]       dm_addr,
  input  logic [XLEN-1:0]       dm_wdata,
  input  logic [3:0]            dm_be,
  output logic [XLEN-1:0]       dm_rdata,
  output logic                  dm_valid,
  output logic                  dm_err,
  // memory side
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_ack,
  // stall indications
  output logic                  if_stall,
  output logic                  dm_stall
);

  localparam int SW = cnt_width(MAX_DM_STREAK);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  mem_arb_state_t        state_reg;
  logic [SW-1:0]         streak_reg;
  logic                  discard_reg;

  logic                  mem_req_reg;
  logic                  mem_we_reg;
  logic [XLEN-1:0]       mem_addr_reg;
  logic [XLEN-1:0]       mem_wdata_reg;
  logic [3:0]            mem_be_reg;

  logic [INST_WIDTH-1:0] if_rdata_reg;
  logic                  if_valid_reg;
  logic                  if_err_reg;
  logic [XLEN-1:0]       dm_rdata_reg;
  logic                  dm_valid_reg;
  logic                  dm_err_reg;

  logic                  grant_if;
  logic                  grant_dm;
  logic                  busy;
  logic                  timeout_expired;
  logic                  if_drop;

  assign busy = (state_reg == BUSY_IF) || (state_reg == BUSY_DM);

  // A fetch completion is dropped if it was flushed earlier or is flushed now
  assign if_drop = discard_reg || if_flush;

  // Grant decision, only taken in IDLE; a saturated streak hands the port to IF
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_reg == IDLE) begin
      if (if_req && !if_flush && (streak_reg == STREAK_MAX)) begin
        grant_if = 1'b1;
      end else if (dm_req) begin
        grant_dm = 1'b1;
      end else if (if_req && !if_flush) begin
        grant_if = 1'b1;
      end
    end
  end

  arb_timeout_counter #(
    .LIMIT (ACK_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (grant_if || grant_dm),
    .enable  (busy),
    .expired (timeout_expired)
  );

  // Arbiter FSM with registered memory-port and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      discard_reg   <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      if_rdata_reg  <= '0;
      if_valid_reg  <= 1'b0;
      if_err_reg    <= 1'b0;
      dm_rdata_reg  <= '0;
      dm_valid_reg  <= 1'b0;
      dm_err_reg    <= 1'b0;
    end else begin
      // completion strobes are single-cycle pulses
      if_valid_reg <= 1'b0;
      if_err_reg   <= 1'b0;
      dm_valid_reg <= 1'b0;
      dm_err_reg   <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (grant_dm) begin
            state_reg     <= BUSY_DM;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= dm_we;
            mem_addr_reg  <= dm_addr;
            mem_wdata_reg <= dm_wdata;
            mem_be_reg    <= dm_be;
            // only DM grants that keep IF waiting extend the streak
            if (!if_req) begin
              streak_reg <= '0;
            end else if (streak_reg != STREAK_MAX) begin
              streak_reg <= streak_reg + 1'b1;
            end
          end else if (grant_if) begin
            state_reg     <= BUSY_IF;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= if_addr;
            mem_wdata_reg <= '0;
            mem_be_reg    <= BE_WORD;
            streak_reg    <= '0;
          end
        end

        BUSY_IF: begin
          if (if_flush) begin
            discard_reg <= 1'b1;
          end
          // acknowledge beats a timeout expiring in the same cycle
          if (mem_ack) begin
            state_reg   <= RESP;
            mem_req_reg <= 1'b0;
            if (!if_drop) begin
              if_valid_reg <= 1'b1;
              if_rdata_reg <= mem_rdata;
            end
          end else if (timeout_expired) begin
            state_reg   <= RESP;
            mem_req_reg <= 1'b0;
            if (!if_drop) begin
              if_valid_reg <= 1'b1;
              if_err_reg   <= 1'b1;
              if_rdata_reg <= '0;
            end
          end
        end

        BUSY_DM: begin
          if (mem_ack) begin
            state_reg    <= RESP;
            mem_req_reg  <= 1'b0;
            dm_valid_reg <= 1'b1;
            dm_rdata_reg <= mem_we_reg ? '0 : mem_rdata;
          end else if (timeout_expired) begin
            state_reg    <= RESP;
            mem_req_reg  <= 1'b0;
            dm_valid_reg <= 1'b1;
            dm_err_reg   <= 1'b1;
            dm_rdata_reg <= '0;
          end
        end

        RESP: begin
          state_reg   <= IDLE;
          discard_reg <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;

  // A flush arriving in the response cycle still cancels the fetch result
  assign if_rdata = if_rdata_reg;
  assign if_valid = if_valid_reg && !if_flush;
  assign if_err   = if_err_reg && !if_flush;

  assign dm_rdata = dm_rdata_reg;
  assign dm_valid = dm_valid_reg;
  assign dm_err   = dm_err_reg;

  assign if_stall = if_req && !if_valid;
  assign dm_stall = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_err;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_valid, dm_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        if_stall, dm_stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_flush  (if_flush),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_err    (if_err),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .dm_err    (dm_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .if_stall  (if_stall),
    .dm_stall  (dm_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // time bound for the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin
    rst_n = 1'b0;
    if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_rdata = '0; mem_ack = 0;

    // reset state
    repeat (3) tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_valids", {28'd0, if_valid, if_err, dm_valid, dm_err}, 32'd0);
    check("rst_rdata", if_rdata | dm_rdata, 32'd0);
    rst_n = 1'b1;

    // ack while idle must be ignored
    mem_ack = 1; mem_rdata = 32'h11111111;
    tick();
    mem_ack = 0; mem_rdata = '0;
    check("idle_ack", {29'd0, mem_req, if_valid, dm_valid}, 32'd0);
    tick();
    $display("txn idle_ack ignored");

    // 1: IF read with 3-cycle ack
    if_req = 1; if_addr = 32'h100;
    check("t1_req_c0", {31'd0, mem_req}, 32'd0);
    tick();
    check("t1_req_c1", {31'd0, mem_req}, 32'd1);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
    check("t1_stall", {31'd0, if_stall}, 32'd1);
    tick();
    check("t1_req_c2", {31'd0, mem_req}, 32'd1);
    tick();
    check("t1_req_c3", {31'd0, mem_req}, 32'd1);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0; mem_rdata = '0;
    check("t1_req_c4", {31'd0, mem_req}, 32'd0);
    check("t1_valid_c4", {30'd0, if_valid, if_err}, 32'd2);
    check("t1_rdata", if_rdata, 32'hDEADBEEF);
    check("t1_stall_c4", {31'd0, if_stall}, 32'd0);
    $display("txn IF read addr=0x100 rdata=0x%08h", if_rdata);
    tick();
    check("t1_c5", {30'd0, mem_req, if_valid}, 32'd0);
    tick();
    check("t1_req_c6", {31'd0, mem_req}, 32'd1);
    mem_ack = 1; mem_rdata = 32'h0000BEEF;
    tick();
    mem_ack = 0; if_req = 0;
    check("t1_valid_c7", {31'd0, if_valid}, 32'd1);
    check("t1_rdata2", if_rdata, 32'h0000BEEF);
    $display("txn IF read addr=0x100 rdata=0x%08h", if_rdata);
    tick();

    // 2: simultaneous IF and DM, DM first
    if_req = 1; if_addr = 32'h180; dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    tick();
    check("t2_dm_addr", mem_addr, 32'h2000);
    check("t2_dm_we", {31'd0, mem_we}, 32'd0);
    mem_ack = 1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 0; dm_req = 0;
    check("t2_dm_valid", {30'd0, dm_valid, if_valid}, 32'd2);
    check("t2_dm_rdata", dm_rdata, 32'h12345678);
    $display("txn DM load addr=0x2000 rdata=0x%08h", dm_rdata);
    tick();
    check("t2_idle", {31'd0, mem_req}, 32'd0);
    tick();
    check("t2_if_addr", mem_addr, 32'h180);
    check("t2_if_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_ack = 0; if_req = 0;
    check("t2_if_valid", {31'd0, if_valid}, 32'd1);
    $display("txn IF read addr=0x180 rdata=0x%08h", if_rdata);
    tick();

    // 3: DM streak limit, IF after 4 DM grants, then DM again
    if_req = 1; if_addr = 32'h300; dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
    for (int g = 0; g < 6; g++) begin
      tick();
      check("t3_req", {31'd0, mem_req}, 32'd1);
      check("t3_addr", mem_addr, (g == 4) ? 32'h300 : 32'h3000);
      mem_ack = 1; mem_rdata = 32'h1000 + g;
      tick();
      mem_ack = 0;
      if (g == 4) begin
        check("t3_if_valid", {30'd0, if_valid, dm_valid}, 32'd2);
        check("t3_if_rdata", if_rdata, 32'h1004);
      end else begin
        check("t3_dm_valid", {30'd0, if_valid, dm_valid}, 32'd1);
        check("t3_dm_rdata", dm_rdata, 32'h1000 + g);
      end
      $display("txn streak grant %0d if_valid=%0b dm_valid=%0b", g, if_valid, dm_valid);
      if (g == 5) begin
        if_req = 0; dm_req = 0;
      end
      tick();
    end

    // 4: flush during BUSY_IF discards result; next fetch unaffected
    if_req = 1; if_addr = 32'h400;
    tick();
    check("t4_req", {31'd0, mem_req}, 32'd1);
    if_flush = 1;
    tick();
    if_flush = 0; if_addr = 32'h500;
    mem_ack = 1; mem_rdata = 32'h00000BAD;
    tick();
    mem_ack = 0;
    check("t4_no_valid", {29'd0, mem_req, if_valid, if_err}, 32'd0);
    $display("txn IF read addr=0x400 flushed");
    tick();
    tick();
    check("t4_next_addr", mem_addr, 32'h500);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0; if_req = 0;
    check("t4_next_valid", {31'd0, if_valid}, 32'd1);
    check("t4_next_rdata", if_rdata, 32'hCAFEF00D);
    $display("txn IF read addr=0x500 rdata=0x%08h", if_rdata);
    tick();

    // 4b: flush in the response cycle suppresses if_valid
    if_req = 1; if_addr = 32'h700;
    tick();
    mem_ack = 1; mem_rdata = 32'h77777777;
    tick();
    mem_ack = 0; if_req = 0; if_flush = 1;
    #1;
    check("t4b_resp_flush", {31'd0, if_valid}, 32'd0);
    $display("txn IF read addr=0x700 flushed in response");
    tick();
    if_flush = 0;

    // 5: DM store with ack returns rdata 0
    dm_req = 1; dm_we = 1; dm_addr = 32'h8000; dm_wdata = 32'hA5A50F0F; dm_be = 4'b0110;
    tick();
    check("t5_we", {31'd0, mem_we}, 32'd1);
    check("t5_wdata", mem_wdata, 32'hA5A50F0F);
    check("t5_be", {28'd0, mem_be}, 32'h6);
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 0; dm_req = 0; dm_we = 0;
    check("t5_valid", {30'd0, dm_valid, dm_err}, 32'd2);
    check("t5_rdata", dm_rdata, 32'd0);
    $display("txn DM store addr=0x8000");
    tick();

    // 6: DM load, then store that times out
    dm_req = 1; dm_we = 0; dm_addr = 32'h8008; dm_be = 4'hF;
    tick();
    mem_ack = 1; mem_rdata = 32'h77;
    tick();
    mem_ack = 0;
    check("t6_load_rdata", dm_rdata, 32'h77);
    $display("txn DM load addr=0x8008 rdata=0x%08h", dm_rdata);
    dm_we = 1; dm_addr = 32'h8004; dm_wdata = 32'h1234;
    tick();
    tick();
    check("t6_busy1", {30'd0, mem_req, mem_we}, 32'd3);
    check("t6_stall", {31'd0, dm_stall}, 32'd1);
    for (int i = 2; i <= 255; i++) begin
      tick();
      check("t6_hold", {30'd0, mem_req, dm_valid}, 32'd2);
    end
    tick();
    check("t6_req_drop", {31'd0, mem_req}, 32'd0);
    check("t6_err", {30'd0, dm_valid, dm_err}, 32'd3);
    check("t6_rdata", dm_rdata, 32'd0);
    $display("txn DM store addr=0x8004 timeout");
    dm_req = 0; dm_we = 0;
    tick();
    check("t6_pulse", {30'd0, dm_valid, dm_err}, 32'd0);

    // 7: ack coincides with timeout expiry, ack wins
    if_req = 1; if_addr = 32'h600;
    tick();
    check("t7_req", {31'd0, mem_req}, 32'd1);
    repeat (254) tick();
    check("t7_req_255", {31'd0, mem_req}, 32'd1);
    mem_ack = 1; mem_rdata = 32'h600D;
    tick();
    mem_ack = 0; if_req = 0;
    check("t7_valid", {30'd0, if_valid, if_err}, 32'd2);
    check("t7_rdata", if_rdata, 32'h600D);
    $display("txn IF read addr=0x600 ack at expiry");
    tick();

    // 8: async reset during BUSY_DM
    dm_req = 1; dm_we = 0; dm_addr = 32'h9000;
    tick();
    check("t8_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_async_req", {31'd0, mem_req}, 32'd0);
    check("t8_rst_rdata", if_rdata, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    dm_addr = 32'hA000;
    rst_n = 1'b1;
    tick();
    check("t8_first_grant", {30'd0, mem_req, dm_valid}, 32'd2);
    check("t8_addr", mem_addr, 32'hA000);
    mem_ack = 1; mem_rdata = 32'hA0A0;
    tick();
    mem_ack = 0; dm_req = 0;
    check("t8_valid", {31'd0, dm_valid}, 32'd1);
    check("t8_rdata", dm_rdata, 32'hA0A0);
    $display("txn DM load addr=0xA000 after reset rdata=0x%08h", dm_rdata);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
